bob: RTL and testbench

- Branch order buffer. Sits directly downstream of the tournament predictor's f1 stage and upstream of its retire-update path.
- Allocates one entry per predicted conditional branch in f1, holding the predictor state captured at prediction time (pc, local history, global BHR, RAS pointer, predicted direction, chooser info).
- At branch retire it pops the oldest entry and presents it as registered update signals: bob_pc_o, bob_lochist_o, bob_bhr_o, bob_chwe_o, bob_chdir_o, bob_valid_o, bob_rasptr_o, bob_brdir_o.
- Back-pressures fetch with bob_stall_o when full.

---
 rtl/bob.sv | 134 +++++++++++++
 tb/tb_bob.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bob.sv
// Branch order buffer: a FIFO of predictor state captured at f1, popped in order at
// conditional-branch retire and presented as registered predictor-update signals.
module bob #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int LH_W  = 10,
    parameter int GH_W  = 12,
    parameter int RP_W  = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             alloc_i,
    input  logic [63:0]      alloc_pc_i,
    input  logic [LH_W-1:0]  alloc_lochist_i,
    input  logic [GH_W-1:0]  alloc_bhr_i,
    input  logic [RP_W-1:0]  alloc_rasptr_i,
    input  logic             alloc_pdir_i,
    input  logic             alloc_chwe_i,
    input  logic             alloc_lpred_i,
    input  logic             rt_condbr_i,
    input  logic             rt_brdir_i,
    output logic             bob_stall_o,
    output logic             bob_valid_o,
    output logic [63:0]      bob_pc_o,
    output logic [LH_W-1:0]  bob_lochist_o,
    output logic [GH_W-1:0]  bob_bhr_o,
    output logic [RP_W-1:0]  bob_rasptr_o,
    output logic             bob_brdir_o,
    output logic             bob_chwe_o,
    output logic             bob_chdir_o,
    output logic [PTR_W:0]   bob_count_o
);

    // Handshake: bob_valid_o is a one-cycle qualifier with no ready; the consumer
    // must take the update outputs in every cycle bob_valid_o is high. On the input
    // side the producer must not raise alloc_i while bob_stall_o is high (unless a
    // pop happens in the same cycle); otherwise the entry is dropped.

    typedef struct packed {
        logic [63:0]     pc;
        logic [LH_W-1:0] lochist;
        logic [GH_W-1:0] bhr;
        logic [RP_W-1:0] rasptr;
        logic            pdir;
        logic            chwe;
        logic            lpred;
    } entry_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    entry_t           mem [DEPTH];
    entry_t           wr_entry;
    entry_t           rd_entry;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             full;
    logic             pop;
    logic             push;

    assign full     = (count == FULL_CNT);
    assign pop      = rt_condbr_i && (count != '0);
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign push     = alloc_i && (!full || pop);
    assign rd_entry = mem[head];

    always_comb begin
        wr_entry         = '0;
        wr_entry.pc      = alloc_pc_i;
        wr_entry.lochist = alloc_lochist_i;
        wr_entry.bhr     = alloc_bhr_i;
        wr_entry.rasptr  = alloc_rasptr_i;
        wr_entry.pdir    = alloc_pdir_i;
        wr_entry.chwe    = alloc_chwe_i;
        wr_entry.lpred   = alloc_lpred_i;
    end

    // Entry storage carries no reset; validity is tracked by head/tail/count.
    always_ff @(posedge clock) begin
        if (push && !flush_i) begin
            mem[tail] <= wr_entry;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            bob_valid_o   <= 1'b0;
            bob_chwe_o    <= 1'b0;
            bob_chdir_o   <= 1'b0;
            bob_pc_o      <= '0;
            bob_lochist_o <= '0;
            bob_bhr_o     <= '0;
            bob_rasptr_o  <= '0;
            bob_brdir_o   <= 1'b0;
        end else if (flush_i) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            bob_valid_o <= 1'b0;
            bob_chwe_o  <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            bob_valid_o <= pop;
            bob_chwe_o  <= pop && rd_entry.chwe;
            // Data outputs hold their last values between pops.
            if (pop) begin
                bob_pc_o      <= rd_entry.pc;
                bob_lochist_o <= rd_entry.lochist;
                bob_bhr_o     <= rd_entry.bhr;
                bob_rasptr_o  <= rd_entry.rasptr;
                bob_brdir_o   <= rd_entry.pdir;
                bob_chdir_o   <= (rd_entry.lpred == rt_brdir_i);
            end
        end
    end

    assign bob_stall_o = full;
    assign bob_count_o = count;

endmodule

// File: tb/tb_bob.sv
// Directed bench for bob: a stimulus process issues alloc/pop/flush cycles and queues
// expected update outputs; a negedge monitor pops the queue whenever bob_valid_o is high.
module tb_bob;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;
    localparam int LH_W  = 10;
    localparam int GH_W  = 12;
    localparam int RP_W  = 4;
    localparam int OW    = 64 + LH_W + GH_W + RP_W + 3;

    logic             clock;
    logic             reset_n;
    logic             flush_i;
    logic             alloc_i;
    logic [63:0]      alloc_pc_i;
    logic [LH_W-1:0]  alloc_lochist_i;
    logic [GH_W-1:0]  alloc_bhr_i;
    logic [RP_W-1:0]  alloc_rasptr_i;
    logic             alloc_pdir_i;
    logic             alloc_chwe_i;
    logic             alloc_lpred_i;
    logic             rt_condbr_i;
    logic             rt_brdir_i;
    logic             bob_stall_o;
    logic             bob_valid_o;
    logic [63:0]      bob_pc_o;
    logic [LH_W-1:0]  bob_lochist_o;
    logic [GH_W-1:0]  bob_bhr_o;
    logic [RP_W-1:0]  bob_rasptr_o;
    logic             bob_brdir_o;
    logic             bob_chwe_o;
    logic             bob_chdir_o;
    logic [PTR_W:0]   bob_count_o;

    bob #(.DEPTH(DEPTH), .PTR_W(PTR_W), .LH_W(LH_W), .GH_W(GH_W), .RP_W(RP_W)) dut (
        .clock(clock), .reset_n(reset_n), .flush_i(flush_i),
        .alloc_i(alloc_i), .alloc_pc_i(alloc_pc_i), .alloc_lochist_i(alloc_lochist_i),
        .alloc_bhr_i(alloc_bhr_i), .alloc_rasptr_i(alloc_rasptr_i),
        .alloc_pdir_i(alloc_pdir_i), .alloc_chwe_i(alloc_chwe_i),
        .alloc_lpred_i(alloc_lpred_i), .rt_condbr_i(rt_condbr_i), .rt_brdir_i(rt_brdir_i),
        .bob_stall_o(bob_stall_o), .bob_valid_o(bob_valid_o), .bob_pc_o(bob_pc_o),
        .bob_lochist_o(bob_lochist_o), .bob_bhr_o(bob_bhr_o), .bob_rasptr_o(bob_rasptr_o),
        .bob_brdir_o(bob_brdir_o), .bob_chwe_o(bob_chwe_o), .bob_chdir_o(bob_chdir_o),
        .bob_count_o(bob_count_o)
    );

    // Bench-side record of an allocated branch.
    typedef struct packed {
        logic [63:0]     pc;
        logic [LH_W-1:0] lochist;
        logic [GH_W-1:0] bhr;
        logic [RP_W-1:0] rasptr;
        logic            pdir;
        logic            chwe;
        logic            lpred;
    } ent_t;

    logic [OW-1:0] exp_q[$];
    ent_t          mdl_q[$];
    int            checks = 0;
    int            errors = 0;

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (act=running req=finished)");
        errors = errors + 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: act=%0h req=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- driver ----------------
    // One clock cycle of stimulus; the model decides what the DUT must produce.
    task automatic cyc(input logic a, input logic [63:0] pc, input logic [GH_W-1:0] bhr,
                       input logic chwe, input logic lpred, input logic pdir,
                       input logic p, input logic brdir, input logic f);
        ent_t e;
        ent_t h;
        logic pop_eff;
        logic alloc_eff;
        e.pc      = pc;
        e.lochist = pc[LH_W+1:2];
        e.bhr     = bhr;
        e.rasptr  = pc[RP_W+3:4];
        e.pdir    = pdir;
        e.chwe    = chwe;
        e.lpred   = lpred;
        alloc_i         = a;
        alloc_pc_i      = e.pc;
        alloc_lochist_i = e.lochist;
        alloc_bhr_i     = e.bhr;
        alloc_rasptr_i  = e.rasptr;
        alloc_pdir_i    = e.pdir;
        alloc_chwe_i    = e.chwe;
        alloc_lpred_i   = e.lpred;
        rt_condbr_i     = p;
        rt_brdir_i      = brdir;
        flush_i         = f;
        if (f) begin
            mdl_q.delete();
        end else begin
            pop_eff   = p && (mdl_q.size() != 0);
            alloc_eff = a && ((mdl_q.size() < DEPTH) || pop_eff);
            if (pop_eff) begin
                h = mdl_q.pop_front();
                exp_q.push_back({h.pc, h.lochist, h.bhr, h.rasptr, h.pdir, h.chwe,
                                 (h.lpred == brdir)});
            end
            if (alloc_eff) mdl_q.push_back(e);
        end
        @(posedge clock);
        #1;
        alloc_i     = 1'b0;
        rt_condbr_i = 1'b0;
        rt_brdir_i  = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic alloc(input logic [63:0] pc, input logic [GH_W-1:0] bhr);
        cyc(1'b1, pc, bhr, 1'b0, 1'b0, pc[8], 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop(input logic brdir);
        cyc(1'b0, 64'h0, '0, 1'b0, 1'b0, 1'b0, 1'b1, brdir, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 64'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Waits for the registered output of the last issued pop, then samples mid-cycle.
    task automatic settle();
        @(negedge clock);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (bob_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {127'h0, bob_valid_o}, 128'h0);
            end else begin
                chk("sb_update",
                    {bob_pc_o, bob_lochist_o, bob_bhr_o, bob_rasptr_o, bob_brdir_o,
                     bob_chwe_o, bob_chdir_o},
                    exp_q.pop_front());
            end
        end else if (bob_chwe_o) begin
            chk("chwe_without_valid", {127'h0, bob_chwe_o}, 128'h0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0; flush_i = 1'b0; alloc_i = 1'b0; alloc_pc_i = '0;
        alloc_lochist_i = '0; alloc_bhr_i = '0; alloc_rasptr_i = '0; alloc_pdir_i = 1'b0;
        alloc_chwe_i = 1'b0; alloc_lpred_i = 1'b0; rt_condbr_i = 1'b0; rt_brdir_i = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_count", bob_count_o, 0);
        chk("reset_stall", bob_stall_o, 0);
        chk("reset_valid", bob_valid_o, 0);
        chk("reset_pc", bob_pc_o, 0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Basic in-order alloc / retire
        alloc(64'h100, 12'd1);
        alloc(64'h200, 12'd2);
        alloc(64'h300, 12'd3);
        chk("basic_count3", bob_count_o, 3);
        pop(1'b1);
        settle();
        chk("basic_pc0", bob_pc_o, 64'h100);
        chk("basic_bhr0", bob_bhr_o, 12'd1);
        #1;
        pop(1'b0);
        pop(1'b1);
        settle();
        chk("basic_pc2", bob_pc_o, 64'h300);
        chk("basic_count0", bob_count_o, 0);
        #1;
        idle();
        settle();
        chk("basic_valid_drop", bob_valid_o, 0);
        #1;

        // Fill, drop when full, alloc+pop when full
        for (int i = 0; i < DEPTH; i++) alloc(64'h1000 + 64'(i) * 64'h10, 12'(i));
        chk("full_stall", bob_stall_o, 1);
        chk("full_count", bob_count_o, 16);
        alloc(64'hDEAD0, 12'hfff);
        chk("full_drop_count", bob_count_o, 16);
        cyc(1'b1, 64'h2000, 12'h200, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("full_allocpop_count", bob_count_o, 16);
        chk("full_allocpop_stall", bob_stall_o, 1);
        pop(1'b0);
        settle();
        chk("full_next_pc_entry2", bob_pc_o, 64'h1010);
        #1;
        for (int i = 0; i < DEPTH - 1; i++) pop(1'b1);
        settle();
        chk("full_last_pc", bob_pc_o, 64'h2000);
        chk("full_drained", bob_count_o, 0);
        #1;

        // Retire when empty
        pop(1'b1);
        settle();
        chk("empty_pop_valid", bob_valid_o, 0);
        chk("empty_pop_count", bob_count_o, 0);
        #1;
        alloc(64'h4440, 12'h44);
        pop(1'b0);
        settle();
        chk("empty_pop_no_ptr_move", bob_pc_o, 64'h4440);
        #1;

        // Chooser training
        cyc(1'b1, 64'h500, 12'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pop(1'b0);
        settle();
        chk("ch_we_a", bob_chwe_o, 1);
        chk("ch_dir_a", bob_chdir_o, 1);
        #1;
        cyc(1'b1, 64'h600, 12'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pop(1'b1);
        settle();
        chk("ch_we_b", bob_chwe_o, 1);
        chk("ch_dir_b", bob_chdir_o, 0);
        #1;
        cyc(1'b1, 64'h700, 12'h7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        pop(1'b1);
        settle();
        chk("ch_we_c", bob_chwe_o, 0);
        chk("ch_dir_c", bob_chdir_o, 1);
        #1;

        // Flush with simultaneous alloc and pop
        for (int i = 0; i < 5; i++) alloc(64'h8000 + 64'(i), 12'(i));
        chk("flush_pre_count", bob_count_o, 5);
        cyc(1'b1, 64'h9999, 12'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("flush_count", bob_count_o, 0);
        chk("flush_valid", bob_valid_o, 0);
        alloc(64'hABC, 12'habc);
        pop(1'b1);
        settle();
        chk("flush_after_pc", bob_pc_o, 64'hABC);
        #1;

        // Steady-state streaming across two pointer wraps
        for (int i = 0; i < 4; i++) alloc(64'hC000 + 64'(i), 12'(i));
        for (int i = 4; i < 44; i++)
            cyc(1'b1, 64'hC000 + 64'(i), 12'(i), 1'(i % 3 == 0), 1'(i % 2), 1'(i % 5 == 0),
                1'b1, 1'(i % 4 == 1), 1'b0);
        chk("stream_count", bob_count_o, 4);
        idle();
        settle();
        chk("stream_last_pc", bob_pc_o, 64'hC000 + 64'd39);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_count", bob_count_o, 0);
        chk("async_rst_pc", bob_pc_o, 0);
        chk("async_rst_bhr", bob_bhr_o, 0);
        chk("async_rst_valid", bob_valid_o, 0);
        mdl_q.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        alloc(64'hF00, 12'hf);
        pop(1'b0);
        idle();
        settle();
        chk("post_rst_pc", bob_pc_o, 64'hF00);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
